// File: rtl/pulse_issue_queue_if.sv
// Descriptor hand-off bus between the pulse issue queue and the element/DAC core.
interface pulse_issue_queue_if #(
    parameter int PHASE_WIDTH    = 17,
    parameter int FREQ_WIDTH     = 9,
    parameter int AMP_WIDTH      = 16,
    parameter int CFG_WIDTH      = 4,
    parameter int ENV_WORD_WIDTH = 24,
    parameter int ENV_LEN_WIDTH  = 12
);
    logic                                    out_valid;
    logic                                    out_ready;
    logic [PHASE_WIDTH-1:0]                  phase;
    logic [FREQ_WIDTH-1:0]                   freq;
    logic [AMP_WIDTH-1:0]                    amp;
    logic [ENV_WORD_WIDTH-ENV_LEN_WIDTH-1:0] env_addr;
    logic [ENV_LEN_WIDTH-1:0]                env_len;
    logic [CFG_WIDTH-1:0]                    cfg;

    modport master (output out_valid, phase, freq, amp, env_addr, env_len, cfg, input out_ready);
    modport slave  (input out_valid, phase, freq, amp, env_addr, env_len, cfg, output out_ready);
endinterface

// File: rtl/pulse_issue_queue.sv
// Small first-word-fall-through FIFO of pulse descriptors captured on cstrobe, plus an
// envelope-length timer that drives pulse_active for the most recently issued pulse.
module pulse_issue_queue #(
    parameter int PHASE_WIDTH    = 17,
    parameter int FREQ_WIDTH     = 9,
    parameter int AMP_WIDTH      = 16,
    parameter int CFG_WIDTH      = 4,
    parameter int ENV_WORD_WIDTH = 24,
    parameter int ENV_LEN_WIDTH  = 12,
    parameter int DEPTH_LOG2     = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cstrobe_in,
    input  logic [PHASE_WIDTH-1:0]    phase_in,
    input  logic [FREQ_WIDTH-1:0]     freq_in,
    input  logic [AMP_WIDTH-1:0]      amp_in,
    input  logic [ENV_WORD_WIDTH-1:0] env_word_in,
    input  logic [CFG_WIDTH-1:0]      cfg_in,
    input  logic                      overflow_clr,
    output logic [DEPTH_LOG2:0]       fill_level,
    output logic                      overflow,
    output logic                      pulse_active,
    pulse_issue_queue_if.master       desc
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [PHASE_WIDTH-1:0]    phase;
        logic [FREQ_WIDTH-1:0]     freq;
        logic [AMP_WIDTH-1:0]      amp;
        logic [ENV_WORD_WIDTH-1:0] env_word;
        logic [CFG_WIDTH-1:0]      cfg;
    } entry_t;

    entry_t                   mem [DEPTH];
    entry_t                   head;
    logic [DEPTH_LOG2-1:0]    wr_ptr, rd_ptr;
    logic [ENV_LEN_WIDTH-1:0] timer, timer_nxt;
    logic                     full, pop, push, drop;

    assign head = mem[rd_ptr];
    assign full = (fill_level == FULL_CNT);
    assign pop  = desc.out_valid & desc.out_ready;
    // A full FIFO still accepts a strobe when the head leaves in the same cycle.
    assign push = cstrobe_in & (~full | pop);
    assign drop = cstrobe_in & full & ~pop;

    assign desc.out_valid = (fill_level != '0);
    assign desc.phase     = head.phase;
    assign desc.freq      = head.freq;
    assign desc.amp       = head.amp;
    assign desc.env_addr  = head.env_word[ENV_WORD_WIDTH-1:ENV_LEN_WIDTH];
    assign desc.env_len   = head.env_word[ENV_LEN_WIDTH-1:0];
    assign desc.cfg       = head.cfg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= '{phase: phase_in, freq: freq_in, amp: amp_in,
                             env_word: env_word_in, cfg: cfg_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            case ({push, pop})
                2'b10:   fill_level <= fill_level + CNT_W'(1);
                2'b01:   fill_level <= fill_level - CNT_W'(1);
                default: fill_level <= fill_level;
            endcase
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop)              overflow <= 1'b1;
            else if (overflow_clr) overflow <= 1'b0;
        end
    end

    // A new pop always restarts the timer, so the newest pulse overrides any in flight.
    always_comb begin
        timer_nxt = timer;
        if (pop)                timer_nxt = head.env_word[ENV_LEN_WIDTH-1:0];
        else if (timer != '0)   timer_nxt = timer - ENV_LEN_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer        <= '0;
            pulse_active <= 1'b0;
        end else begin
            timer        <= timer_nxt;
            pulse_active <= (timer_nxt != '0);
        end
    end
endmodule

// File: tb/tb_pulse_issue_queue.sv
// Directed bench for pulse_issue_queue: reset, single pulse, back-pressure, full push/pop,
// overflow clear race and envelope timer override/zero.
module tb_pulse_issue_queue;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cstrobe_in = 1'b0;
    logic        overflow_clr = 1'b0;
    logic [16:0] phase_in = '0;
    logic [8:0]  freq_in = '0;
    logic [15:0] amp_in = '0;
    logic [23:0] env_word_in = '0;
    logic [3:0]  cfg_in = '0;
    logic [2:0]  fill_level;
    logic        overflow;
    logic        pulse_active;
    int          checks = 0;
    int          failures = 0;

    pulse_issue_queue_if desc ();

    pulse_issue_queue dut (
        .clk(clk), .rst_n(rst_n), .cstrobe_in(cstrobe_in),
        .phase_in(phase_in), .freq_in(freq_in), .amp_in(amp_in),
        .env_word_in(env_word_in), .cfg_in(cfg_in), .overflow_clr(overflow_clr),
        .fill_level(fill_level), .overflow(overflow), .pulse_active(pulse_active),
        .desc(desc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16:0] exp_phase(input int k);
        return 17'(17'h1000 + k);
    endfunction

    function automatic logic [11:0] exp_addr(input int k);
        return 12'(12'hA00 + k);
    endfunction

    task automatic set_in(input int k, input logic [11:0] len);
        phase_in    = exp_phase(k);
        freq_in     = 9'(k);
        amp_in      = 16'(16'h0100 + k);
        env_word_in = {exp_addr(k), len};
        cfg_in      = 4'(k);
    endtask

    task automatic test_reset();
        checks++;
        if (desc.out_valid !== 1'b0 || fill_level !== 3'd0 || overflow !== 1'b0 ||
            pulse_active !== 1'b0 || desc.phase !== '0 || desc.env_len !== '0) begin
            failures++;
            $display("FAIL reset_initial: valid=%b fill=%0d ovf=%b act=%b phase=%h len=%h required all 0",
                     desc.out_valid, fill_level, overflow, pulse_active, desc.phase, desc.env_len);
        end
        @(negedge clk) rst_n = 1'b1;
        desc.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_in(k, 12'd50);
            cstrobe_in = 1'b1;
            tick();
        end
        cstrobe_in = 1'b0;
        desc.out_ready = 1'b1;
        tick();
        desc.out_ready = 1'b0;
        checks++;
        if (fill_level !== 3'd3 || pulse_active !== 1'b1 || desc.phase !== exp_phase(1)) begin
            failures++;
            $display("FAIL reset_prequeue: fill=%0d act=%b phase=%h required fill=3 act=1 phase=%h",
                     fill_level, pulse_active, desc.phase, exp_phase(1));
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (desc.out_valid !== 1'b0 || fill_level !== 3'd0 || overflow !== 1'b0 ||
            pulse_active !== 1'b0 || desc.phase !== '0 || desc.amp !== '0 ||
            desc.env_addr !== '0 || desc.env_len !== '0 || desc.freq !== '0 || desc.cfg !== '0) begin
            failures++;
            $display("FAIL reset_async: valid=%b fill=%0d act=%b phase=%h amp=%h addr=%h required all 0",
                     desc.out_valid, fill_level, pulse_active, desc.phase, desc.amp, desc.env_addr);
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
        checks++;
        if (fill_level !== 3'd0 || desc.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: fill=%0d valid=%b required fill=0 valid=0",
                     fill_level, desc.out_valid);
        end
    endtask

    task automatic test_single_pulse();
        int cnt;
        phase_in = 17'h1ABCD; amp_in = 16'h7FFF; env_word_in = 24'h123010;
        freq_in = 9'h055; cfg_in = 4'h9;
        cstrobe_in = 1'b1;
        desc.out_ready = 1'b1;
        tick();
        cstrobe_in = 1'b0;
        checks++;
        if (desc.out_valid !== 1'b1 || desc.phase !== 17'h1ABCD || desc.amp !== 16'h7FFF ||
            desc.env_addr !== 12'h123 || desc.env_len !== 12'h010 || desc.freq !== 9'h055 ||
            desc.cfg !== 4'h9 || pulse_active !== 1'b0) begin
            failures++;
            $display("FAIL single_head: valid=%b phase=%h amp=%h addr=%h len=%h act=%b required 1 1abcd 7fff 123 010 0",
                     desc.out_valid, desc.phase, desc.amp, desc.env_addr, desc.env_len, pulse_active);
        end
        tick();
        desc.out_ready = 1'b0;
        checks++;
        if (desc.out_valid !== 1'b0 || pulse_active !== 1'b1) begin
            failures++;
            $display("FAIL single_pop: valid=%b act=%b required valid=0 act=1", desc.out_valid, pulse_active);
        end
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (pulse_active) cnt++;
            tick();
        end
        checks++;
        if (cnt != 16) begin
            failures++;
            $display("FAIL single_len: active cycles=%0d required 16", cnt);
        end
    endtask

    task automatic test_back_pressure();
        desc.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_in(k, 12'd0);
            cstrobe_in = 1'b1;
            tick();
        end
        checks++;
        if (fill_level !== 3'd4 || desc.phase !== exp_phase(0) || overflow !== 1'b0) begin
            failures++;
            $display("FAIL bp_full: fill=%0d phase=%h ovf=%b required fill=4 phase=%h ovf=0",
                     fill_level, desc.phase, overflow, exp_phase(0));
        end
        set_in(4, 12'd0);
        tick();
        cstrobe_in = 1'b0;
        checks++;
        if (fill_level !== 3'd4 || overflow !== 1'b1 || desc.phase !== exp_phase(0) ||
            desc.env_addr !== exp_addr(0)) begin
            failures++;
            $display("FAIL bp_drop: fill=%0d ovf=%b phase=%h required fill=4 ovf=1 phase=%h",
                     fill_level, overflow, desc.phase, exp_phase(0));
        end
        desc.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (desc.out_valid !== 1'b1 || desc.phase !== exp_phase(k) || desc.env_addr !== exp_addr(k)) begin
                failures++;
                $display("FAIL bp_order%0d: valid=%b phase=%h required valid=1 phase=%h",
                         k, desc.out_valid, desc.phase, exp_phase(k));
            end
            tick();
        end
        desc.out_ready = 1'b0;
        checks++;
        if (desc.out_valid !== 1'b0 || fill_level !== 3'd0) begin
            failures++;
            $display("FAIL bp_empty: valid=%b fill=%0d required 0 0", desc.out_valid, fill_level);
        end
    endtask

    task automatic test_full_push_pop();
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        for (int k = 10; k < 14; k++) begin
            set_in(k, 12'd0);
            cstrobe_in = 1'b1;
            tick();
        end
        set_in(14, 12'd0);
        desc.out_ready = 1'b1;
        tick();
        cstrobe_in = 1'b0;
        desc.out_ready = 1'b0;
        checks++;
        if (fill_level !== 3'd4 || overflow !== 1'b0 || desc.phase !== exp_phase(11)) begin
            failures++;
            $display("FAIL full_pushpop: fill=%0d ovf=%b phase=%h required fill=4 ovf=0 phase=%h",
                     fill_level, overflow, desc.phase, exp_phase(11));
        end
        desc.out_ready = 1'b1;
        for (int k = 11; k < 15; k++) begin
            checks++;
            if (desc.out_valid !== 1'b1 || desc.phase !== exp_phase(k)) begin
                failures++;
                $display("FAIL full_order%0d: valid=%b phase=%h required valid=1 phase=%h",
                         k, desc.out_valid, desc.phase, exp_phase(k));
            end
            tick();
        end
        desc.out_ready = 1'b0;
    endtask

    task automatic test_overflow_clear();
        for (int k = 20; k < 24; k++) begin
            set_in(k, 12'd0);
            cstrobe_in = 1'b1;
            tick();
        end
        set_in(24, 12'd0);
        tick();
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set: ovf=%b required 1", overflow);
        end
        set_in(25, 12'd0);
        overflow_clr = 1'b1;
        tick();
        cstrobe_in = 1'b0;
        checks++;
        if (overflow !== 1'b1 || fill_level !== 3'd4) begin
            failures++;
            $display("FAIL ovf_race: ovf=%b fill=%0d required ovf=1 fill=4", overflow, fill_level);
        end
        tick();
        overflow_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0 || desc.phase !== exp_phase(20)) begin
            failures++;
            $display("FAIL ovf_clear: ovf=%b phase=%h required ovf=0 phase=%h",
                     overflow, desc.phase, exp_phase(20));
        end
        desc.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        desc.out_ready = 1'b0;
        checks++;
        if (fill_level !== 3'd0) begin
            failures++;
            $display("FAIL ovf_drain: fill=%0d required 0", fill_level);
        end
    endtask

    task automatic test_timer();
        int cnt;
        set_in(30, 12'd100);
        cstrobe_in = 1'b1;
        tick();
        set_in(31, 12'd5);
        tick();
        cstrobe_in = 1'b0;
        desc.out_ready = 1'b1;
        tick();
        desc.out_ready = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        checks++;
        if (pulse_active !== 1'b1 || desc.env_len !== 12'd5) begin
            failures++;
            $display("FAIL timer_first: act=%b len=%0d required act=1 len=5", pulse_active, desc.env_len);
        end
        desc.out_ready = 1'b1;
        tick();
        desc.out_ready = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (pulse_active) cnt++;
            tick();
        end
        checks++;
        if (cnt != 5) begin
            failures++;
            $display("FAIL timer_override: active cycles=%0d required 5", cnt);
        end
        set_in(32, 12'd0);
        cstrobe_in = 1'b1;
        tick();
        cstrobe_in = 1'b0;
        desc.out_ready = 1'b1;
        tick();
        desc.out_ready = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (pulse_active) cnt++;
            tick();
        end
        checks++;
        if (cnt != 0 || desc.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL timer_zero: active cycles=%0d valid=%b required 0 0", cnt, desc.out_valid);
        end
    endtask

    initial begin
        desc.out_ready = 1'b0;
        #1;
        test_reset();
        test_single_pulse();
        test_back_pressure();
        test_full_push_pop();
        test_overflow_clear();
        test_timer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
